b_powermonitor_pgood_capture: RTL

- Input-side companion to the power-monitor output block.
- Samples up to 32 external converter power-good lines, synchronizes and debounces them on a prescaled sample tick, and presents a stable status word for firmware.
- Latches rising and falling transitions in sticky registers, raises an interrupt on any falling edge, and pulses an end-of-sample strobe on every sample tick.
- Sits between the pgood input pins and UDB status registers read by firmware.

---
 rtl/b_powermonitor_pgood_capture.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/b_powermonitor_pgood_capture.sv
// ---------------------------------------------------------------------------
// b_powermonitor_pgood_capture
//
// Purpose:
//   Input-side capture for up to 32 converter power-good lines. Each active
//   line is brought into the clock domain with a 2-FF synchronizer. A
//   prescaled sample tick drives a per-channel debouncer. A new level is
//   accepted only after DebounceCount consecutive ticks that disagree with
//   the current debounced level. Transitions of the debounced level are
//   latched in sticky registers that firmware can clear. Any latched falling
//   edge raises irq.
//
// Parameters:
//   NumConverters  active channels (1..32); higher indices read as 0
//   SamplePeriod   clock cycles per sample tick (1..256)
//   DebounceCount  consecutive disagreeing ticks to accept a level (1..255)
//
// Ports:
//   clock         in   component clock, all logic on posedge
//   reset         in   synchronous active-high reset
//   pgood_in      in   [31:0] raw asynchronous power-good inputs
//   sample_en     in   1 = prescaler runs, 0 = prescaler held at 0, no ticks
//   clr_req       in   one-cycle request to clear sticky bits
//   clr_mask      in   [31:0] sticky bits to clear when clr_req = 1
//   pgood_status  out  [31:0] debounced level per channel
//   all_good      out  AND of the active pgood_status bits
//   rise_sticky   out  [31:0] latched 0->1 transitions of pgood_status
//   fall_sticky   out  [31:0] latched 1->0 transitions of pgood_status
//   irq           out  registered OR of fall_sticky
//   sample_done   out  one-cycle pulse, registered sample tick
// ---------------------------------------------------------------------------
module b_powermonitor_pgood_capture #(
  parameter int unsigned NumConverters = 1,
  parameter int unsigned SamplePeriod  = 8,
  parameter int unsigned DebounceCount = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pgood_in,
  input  logic        sample_en,
  input  logic        clr_req,
  input  logic [31:0] clr_mask,
  output logic [31:0] pgood_status,
  output logic        all_good,
  output logic [31:0] rise_sticky,
  output logic [31:0] fall_sticky,
  output logic        irq,
  output logic        sample_done
);

  // Bit i is set for every active channel. Computed one bit wider so that
  // NumConverters = 32 does not shift the one out of range.
  localparam logic [32:0] ONE_HOT     = 33'd1 << NumConverters;
  localparam logic [31:0] ACTIVE_MASK = 32'(ONE_HOT - 33'd1);

  localparam logic [7:0] PCNT_LAST = 8'(SamplePeriod - 1);
  localparam logic [7:0] CNT_LAST  = 8'(DebounceCount - 1);

  // -------------------------------------------------------------------------
  // Synchronizer. Unused channels are masked at the input so nothing
  // downstream of them can ever toggle.
  // -------------------------------------------------------------------------
  logic [31:0] sync1_q;
  logic [31:0] sync2_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= pgood_in & ACTIVE_MASK;
      sync2_q <= sync1_q;
    end
  end

  // -------------------------------------------------------------------------
  // Prescaler. pcnt only wraps through the explicit compare, so with
  // SamplePeriod = 1 it sits at 0 and every enabled cycle is a tick.
  // -------------------------------------------------------------------------
  logic [7:0] pcnt_q;
  logic [7:0] pcnt_d;
  logic       tick;

  assign tick = sample_en & (pcnt_q == PCNT_LAST);

  always_comb begin
    pcnt_d = pcnt_q;
    if (!sample_en) begin
      pcnt_d = '0;
    end else if (pcnt_q == PCNT_LAST) begin
      pcnt_d = '0;
    end else begin
      pcnt_d = pcnt_q + 8'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

  // -------------------------------------------------------------------------
  // Per-channel debounce. The counter counts ticks on which the synchronized
  // input disagrees with the debounced level. Any agreeing tick restarts it,
  // so only an unbroken run of DebounceCount disagreeing ticks is accepted.
  // The counter never exceeds DebounceCount-1.
  // -------------------------------------------------------------------------
  logic [31:0] status_q;
  logic [31:0] status_d;

  for (genvar gi = 0; gi < 32; gi++) begin : g_chan
    if (gi < NumConverters) begin : g_active
      logic [7:0] cnt_q;
      logic [7:0] cnt_d;
      logic       level_d;

      always_comb begin
        cnt_d   = cnt_q;
        level_d = status_q[gi];
        if (tick) begin
          if (sync2_q[gi] == status_q[gi]) begin
            cnt_d = '0;
          end else if (cnt_q == CNT_LAST) begin
            level_d = sync2_q[gi];
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end

      always_ff @(posedge clock) begin
        if (reset) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign status_d[gi] = level_d;
    end else begin : g_unused
      assign status_d[gi] = 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Sticky transition registers. The set term is OR-ed in after the clear,
  // so a transition landing on the same edge as a firmware clear is kept.
  // -------------------------------------------------------------------------
  logic [31:0] rise_q;
  logic [31:0] rise_d;
  logic [31:0] fall_q;
  logic [31:0] fall_d;
  logic [31:0] clr_bits;
  logic [31:0] rise_set;
  logic [31:0] fall_set;

  assign clr_bits = clr_req ? clr_mask : 32'd0;
  assign rise_set = status_d & ~status_q;
  assign fall_set = ~status_d & status_q;

  always_comb begin
    rise_d = ((rise_q & ~clr_bits) | rise_set) & ACTIVE_MASK;
    fall_d = ((fall_q & ~clr_bits) | fall_set) & ACTIVE_MASK;
  end

  // -------------------------------------------------------------------------
  // Status, sticky, irq and sample strobe registers. irq is taken from the
  // registered fall_sticky and therefore lags it by one cycle.
  // -------------------------------------------------------------------------
  logic irq_q;
  logic done_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      status_q <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      irq_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      status_q <= status_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      irq_q    <= |fall_q;
      done_q   <= tick;
    end
  end

  assign pgood_status = status_q;
  assign rise_sticky  = rise_q;
  assign fall_sticky  = fall_q;
  assign irq          = irq_q;
  assign sample_done  = done_q;
  assign all_good     = &status_q[NumConverters-1:0];

endmodule
